// File: rtl/m68k_bus_activity_monitor.sv
// Purpose: counts M68000 bus events and GPIO changes, detects GPIO pattern cycles, flags stalls via an idle watchdog.
// Latency: register reads return one cycle after reg_rd_en; pattern_pulse follows the completing GPIO change by one cycle.
// Backpressure: none; one read per cycle is accepted. Define SNAPSHOT_EN for atomic reads (addr 0 latches shadows for 1-6).
module m68k_bus_activity_monitor #(
  parameter int CNT_WIDTH      = 32,
  parameter int NUM_GPIO       = 2,
  parameter int PATTERN_LEN    = 4,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                clk_50mhz,
  input  logic                rst_n,
  input  logic                arm,
  input  logic                clr,
  input  logic                cpu_rd_ena,
  input  logic                cpu_wr_ena,
  input  logic                cpu_data_ack,
  input  logic [2:0]          cpu_fc,
  input  logic [NUM_GPIO-1:0] gpio_in,
  input  logic                reg_rd_en,
  input  logic [2:0]          reg_addr,
  output logic [31:0]         reg_rd_data,
  output logic                reg_rd_valid,
  output logic                stall,
  output logic                pattern_pulse
);

  localparam int PH_W   = (PATTERN_LEN > 1) ? $clog2(PATTERN_LEN) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [PH_W-1:0]      PH_LAST   = PH_W'(PATTERN_LEN - 1);
  localparam logic [PH_W-1:0]      PH_ONE    = PH_W'(1);
  localparam logic [IDLE_W-1:0]    IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0]    IDLE_ONE  = IDLE_W'(1);
  localparam logic [31:0]          ID_WORD   = 32'h6800_0A01;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_STALLED = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic [NUM_GPIO-1:0]   gpio_prev;
  logic [CNT_WIDTH-1:0]  ifetch_cnt, dread_cnt, write_cnt, gchg_cnt, pat_cnt;
  logic [PH_W-1:0]       phase;
  logic [IDLE_W-1:0]     idle_cnt;

  logic active, ev_ifetch, ev_dread, ev_write, ev_gchg, pat_done;
  logic [15:0] gpio_ext;
  logic [31:0] phase_ext;
  logic [31:0] status_word;
  logic [31:0] live_word;
  logic [31:0] rd_word;

  // clr outranks every event in the same cycle, so it is folded into the qualifier
  assign active    = arm & ~clr;
  assign ev_ifetch = active & cpu_rd_ena & cpu_data_ack & (cpu_fc == 3'b010);
  assign ev_dread  = active & cpu_rd_ena & cpu_data_ack & (cpu_fc != 3'b010);
  assign ev_write  = active & cpu_wr_ena & cpu_data_ack;
  assign ev_gchg   = active & (gpio_in != gpio_prev);
  assign pat_done  = ev_gchg & (phase == PH_LAST);

  // previous GPIO levels track the pins every cycle, armed or not
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) gpio_prev <= '0;
    else        gpio_prev <= gpio_in;
  end

  // saturating event counters
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      ifetch_cnt <= '0;
      dread_cnt  <= '0;
      write_cnt  <= '0;
      gchg_cnt   <= '0;
      pat_cnt    <= '0;
    end else if (clr) begin
      ifetch_cnt <= '0;
      dread_cnt  <= '0;
      write_cnt  <= '0;
      gchg_cnt   <= '0;
      pat_cnt    <= '0;
    end else begin
      if (ev_ifetch && ifetch_cnt != CNT_MAX) ifetch_cnt <= ifetch_cnt + CNT_ONE;
      if (ev_dread  && dread_cnt  != CNT_MAX) dread_cnt  <= dread_cnt  + CNT_ONE;
      if (ev_write  && write_cnt  != CNT_MAX) write_cnt  <= write_cnt  + CNT_ONE;
      if (ev_gchg   && gchg_cnt   != CNT_MAX) gchg_cnt   <= gchg_cnt   + CNT_ONE;
      if (pat_done  && pat_cnt    != CNT_MAX) pat_cnt    <= pat_cnt    + CNT_ONE;
    end
  end

  // pattern phase wraps after PATTERN_LEN changes and fires a one-cycle pulse
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      phase         <= '0;
      pattern_pulse <= 1'b0;
    end else begin
      pattern_pulse <= pat_done;
      if (clr)          phase <= '0;
      else if (pat_done) phase <= '0;
      else if (ev_gchg)  phase <= phase + PH_ONE;
    end
  end

  // watchdog idle counter: runs only while armed in RUN, frozen once stalled
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n)                    idle_cnt <= '0;
    else if (clr)                  idle_cnt <= '0;
    else if (arm && state == S_RUN) idle_cnt <= ev_gchg ? '0 : idle_cnt + IDLE_ONE;
  end

  // FSM state register
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // FSM next state: start on first fetch, stall after TIMEOUT_CYCLES quiet cycles
  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = S_IDLE;
    end else if (arm) begin
      case (state)
        S_IDLE:    if (ev_ifetch) state_nx = S_RUN;
        S_RUN:     if (!ev_gchg && idle_cnt == IDLE_LAST) state_nx = S_STALLED;
        S_STALLED: state_nx = S_STALLED;
        default:   state_nx = S_IDLE;
      endcase
    end
  end

  // FSM outputs: stall is sticky because STALLED is only left through clr or reset
  always_comb begin
    stall = (state == S_STALLED);
  end

  assign gpio_ext    = 16'(gpio_in);
  assign phase_ext   = 32'(phase);
  assign status_word = {16'b0, gpio_ext[7:0], 3'b0, stall, phase_ext[1:0], state};

  // live register map
  always_comb begin
    live_word = '0;
    case (reg_addr)
      3'd0: live_word = 32'(ifetch_cnt);
      3'd1: live_word = 32'(dread_cnt);
      3'd2: live_word = 32'(write_cnt);
      3'd3: live_word = 32'(gchg_cnt);
      3'd4: live_word = 32'(pat_cnt);
      3'd5: live_word = status_word;
      3'd6: live_word = 32'(idle_cnt);
      3'd7: live_word = ID_WORD;
    endcase
  end

`ifdef SNAPSHOT_EN
  logic [CNT_WIDTH-1:0] sh_dread, sh_write, sh_gchg, sh_pat;
  logic [31:0]          sh_status;
  logic [IDLE_W-1:0]    sh_idle;

  // reading addr 0 freezes the rest of the map so a multi-register read is coherent
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n || clr) begin
      sh_dread  <= '0;
      sh_write  <= '0;
      sh_gchg   <= '0;
      sh_pat    <= '0;
      sh_status <= '0;
      sh_idle   <= '0;
    end else if (reg_rd_en && reg_addr == 3'd0) begin
      sh_dread  <= dread_cnt;
      sh_write  <= write_cnt;
      sh_gchg   <= gchg_cnt;
      sh_pat    <= pat_cnt;
      sh_status <= status_word;
      sh_idle   <= idle_cnt;
    end
  end

  // addresses 1-6 come from the shadows; 0 and 7 stay live
  always_comb begin
    rd_word = live_word;
    case (reg_addr)
      3'd1:    rd_word = 32'(sh_dread);
      3'd2:    rd_word = 32'(sh_write);
      3'd3:    rd_word = 32'(sh_gchg);
      3'd4:    rd_word = 32'(sh_pat);
      3'd5:    rd_word = sh_status;
      3'd6:    rd_word = 32'(sh_idle);
      default: rd_word = live_word;
    endcase
  end
`else
  // every address reads live values
  always_comb begin
    rd_word = live_word;
  end
`endif

  // read port: data captured from pre-update values, held until the next read
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      reg_rd_data  <= '0;
      reg_rd_valid <= 1'b0;
    end else begin
      reg_rd_valid <= reg_rd_en;
      if (reg_rd_en) reg_rd_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_m68k_bus_activity_monitor.sv
// Bench for m68k_bus_activity_monitor: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the monitor.
module tb_m68k_bus_activity_monitor;
  localparam int CW   = 8;
  localparam int NG   = 2;
  localparam int PL   = 4;
  localparam int TO   = 100;
  localparam int CMAX = (1 << CW) - 1;

  logic        clk_50mhz = 1'b0;
  logic        rst_n = 1'b1;
  logic        arm = 1'b0, clr = 1'b0;
  logic        cpu_rd_ena = 1'b0, cpu_wr_ena = 1'b0, cpu_data_ack = 1'b0;
  logic [2:0]  cpu_fc = 3'b0;
  logic [NG-1:0] gpio_in = '0;
  logic        reg_rd_en = 1'b0;
  logic [2:0]  reg_addr = 3'b0;
  logic [31:0] reg_rd_data;
  logic        reg_rd_valid, stall, pattern_pulse;

  m68k_bus_activity_monitor #(
    .CNT_WIDTH(CW), .NUM_GPIO(NG), .PATTERN_LEN(PL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_50mhz(clk_50mhz), .rst_n(rst_n), .arm(arm), .clr(clr),
    .cpu_rd_ena(cpu_rd_ena), .cpu_wr_ena(cpu_wr_ena), .cpu_data_ack(cpu_data_ack),
    .cpu_fc(cpu_fc), .gpio_in(gpio_in), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
    .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid), .stall(stall),
    .pattern_pulse(pattern_pulse)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  int total = 0;
  int bad = 0;
  int pulse_seen = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_if, m_dr, m_wr, m_gc, m_pat, m_phase, m_idle, m_state;  // state: 0 idle, 1 run, 2 stalled
  logic [NG-1:0] m_prev;
  logic [31:0] e_data;
  logic e_valid, e_pulse;
`ifdef SNAPSHOT_EN
  logic [31:0] sh [8];
`endif

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic [31:0] live_val(input int a, input logic [NG-1:0] g);
    logic [31:0] ph, st;
    ph = m_phase;
    st = m_state;
    case (a)
      0: return m_if;
      1: return m_dr;
      2: return m_wr;
      3: return m_gc;
      4: return m_pat;
      5: return {16'b0, 6'b0, g, 3'b0, (m_state == 2), ph[1:0], st[1:0]};
      6: return m_idle;
      default: return 32'h6800_0A01;
    endcase
  endfunction

  always @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      m_if = 0; m_dr = 0; m_wr = 0; m_gc = 0; m_pat = 0;
      m_phase = 0; m_idle = 0; m_state = 0; m_prev = '0;
      e_data = 0; e_valid = 0; e_pulse = 0;
`ifdef SNAPSHOT_EN
      for (int k = 0; k < 8; k++) sh[k] = 0;
`endif
    end else begin
      logic gch, is_if, is_dr, is_wr;
      e_valid = reg_rd_en;
      if (reg_rd_en) begin
        e_data = live_val(int'(reg_addr), gpio_in);
`ifdef SNAPSHOT_EN
        if (reg_addr != 3'd0 && reg_addr != 3'd7) e_data = sh[reg_addr];
`endif
      end
`ifdef SNAPSHOT_EN
      if (clr) for (int k = 0; k < 8; k++) sh[k] = 0;
      else if (reg_rd_en && reg_addr == 3'd0)
        for (int k = 1; k < 7; k++) sh[k] = live_val(k, gpio_in);
`endif
      gch = (gpio_in != m_prev);
      m_prev = gpio_in;
      e_pulse = 0;
      is_if = cpu_rd_ena && cpu_data_ack && cpu_fc == 3'b010;
      is_dr = cpu_rd_ena && cpu_data_ack && cpu_fc != 3'b010;
      is_wr = cpu_wr_ena && cpu_data_ack;
      if (clr) begin
        m_if = 0; m_dr = 0; m_wr = 0; m_gc = 0; m_pat = 0;
        m_phase = 0; m_idle = 0; m_state = 0;
      end else if (arm) begin
        // watchdog and mode use values from before this cycle's updates
        if (m_state == 0) begin
          if (is_if) m_state = 1;
        end else if (m_state == 1) begin
          if (gch) m_idle = 0;
          else begin
            if (m_idle == TO - 1) m_state = 2;
            m_idle = m_idle + 1;
          end
        end
        if (is_if) m_if = sat(m_if);
        if (is_dr) m_dr = sat(m_dr);
        if (is_wr) m_wr = sat(m_wr);
        if (gch) begin
          m_gc = sat(m_gc);
          m_phase = m_phase + 1;
          if (m_phase == PL) begin
            m_phase = 0;
            m_pat = sat(m_pat);
            e_pulse = 1;
          end
        end
      end
    end
  end

  // per-cycle compare, away from the active edge
  always @(negedge clk_50mhz) begin
    if (chk_en) begin
      check("rd_valid", {31'b0, reg_rd_valid}, {31'b0, e_valid});
      check("rd_data", reg_rd_data, e_data);
      check("stall", {31'b0, stall}, {31'b0, m_state == 2});
      check("pattern_pulse", {31'b0, pattern_pulse}, {31'b0, e_pulse});
      if (pattern_pulse) pulse_seen++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic quiet();
    cpu_rd_ena = 0; cpu_wr_ena = 0; cpu_data_ack = 0; cpu_fc = 3'b0;
    clr = 0; reg_rd_en = 0;
  endtask

  // kind 0 ifetch, 1 data read, 2 write
  task automatic bus(input int kind);
    cpu_data_ack = 1;
    cpu_rd_ena = (kind != 2);
    cpu_wr_ena = (kind == 2);
    cpu_fc = (kind == 0) ? 3'b010 : 3'b101;
    tick();
    quiet();
  endtask

  task automatic pulse_clr();
    clr = 1;
    tick();
    clr = 0;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string nm);
    reg_rd_en = 1;
    reg_addr = a;
    tick();
    reg_rd_en = 0;
    check(nm, reg_rd_data, exp);
  endtask

  task automatic async_reset();
    #2 rst_n = 0;
    #1;
    check("arst_data", reg_rd_data, 32'h0);
    check("arst_flags", {29'b0, reg_rd_valid, stall, pattern_pulse}, 32'h0);
    @(posedge clk_50mhz);
    #1 rst_n = 1;
  endtask

  initial begin
    #2 rst_n = 0;
    chk_en = 1;
    repeat (3) tick();
    rst_n = 1;
    tick();

    // reset values
    check("reset_stall", {31'b0, stall}, 32'h0);
    rd_chk(3'd7, 32'h6800_0A01, "id_reg");
    rd_chk(3'd0, 32'h0, "reset_ifetch");

    // basic bus event counting
    arm = 1;
    repeat (10) bus(0);
    repeat (3) bus(1);
    repeat (2) bus(2);
    rd_chk(3'd0, 32'd10, "ifetch_cnt");
    rd_chk(3'd1, 32'd3, "dread_cnt");
    rd_chk(3'd2, 32'd2, "write_cnt");
    rd_chk(3'd5, 32'h1, "status_run");

    // GPIO pattern cycles
    pulse_clr();
    pulse_seen = 0;
    for (int r = 0; r < 10; r++) begin
      gpio_in = 2'b01; tick();
      gpio_in = 2'b10; tick();
      gpio_in = 2'b11; tick();
      gpio_in = 2'b00; tick();
    end
    tick();
    check("pulse_count", pulse_seen, 32'd10);
    rd_chk(3'd3, 32'd40, "gchg_cnt");
    rd_chk(3'd4, 32'd10, "pat_cnt");
    rd_chk(3'd5, 32'h0, "status_phase0");

    // watchdog
    pulse_clr();
    bus(0);
    repeat (TO - 1) tick();
    check("stall_early", {31'b0, stall}, 32'h0);
    tick();
    check("stall_set", {31'b0, stall}, 32'h1);
    rd_chk(3'd6, TO, "idle_frozen");
    gpio_in = 2'b01;
    tick();
    check("stall_sticky", {31'b0, stall}, 32'h1);
    rd_chk(3'd5, 32'h0000_0116, "status_stalled");
    pulse_clr();
    check("stall_clr", {31'b0, stall}, 32'h0);
    rd_chk(3'd5, 32'h0000_0100, "status_idle");

    // saturation and clr priority
    repeat (300) bus(2);
    rd_chk(3'd2, CMAX, "write_sat");
    cpu_wr_ena = 1; cpu_data_ack = 1; clr = 1;
    tick();
    quiet();
    rd_chk(3'd2, 32'h0, "clr_priority");

    // disarmed hold
    pulse_clr();
    repeat (5) bus(0);
    arm = 0;
    for (int i = 0; i < 50; i++) begin
      cpu_rd_ena = 1'($urandom_range(0, 1));
      cpu_wr_ena = 1'($urandom_range(0, 1));
      cpu_data_ack = 1'($urandom_range(0, 1));
      cpu_fc = 3'($urandom_range(0, 7));
      gpio_in = 2'($urandom_range(0, 3));
      tick();
    end
    quiet();
    rd_chk(3'd0, 32'd5, "hold_ifetch");
    rd_chk(3'd3, 32'd0, "hold_gchg");
    arm = 1;
    repeat (3) bus(0);
    rd_chk(3'd0, 32'd8, "resume_ifetch");

    // snapshot vs live status
    gpio_in = 2'b00;
    tick();
    pulse_clr();
    rd_chk(3'd0, 32'h0, "snap_ifetch");
    repeat (5) bus(0);
`ifdef SNAPSHOT_EN
    rd_chk(3'd5, 32'h0, "status_snapshot");
`else
    rd_chk(3'd5, 32'h1, "status_live");
`endif

    // random traffic with one asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      arm = ($urandom_range(0, 15) != 0);
      clr = ($urandom_range(0, 199) == 0);
      cpu_rd_ena = 1'($urandom_range(0, 1));
      cpu_wr_ena = 1'($urandom_range(0, 1));
      cpu_data_ack = 1'($urandom_range(0, 1));
      cpu_fc = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 127) == 0) gpio_in = 2'($urandom_range(0, 3));
      reg_rd_en = 1'($urandom_range(0, 1));
      reg_addr = 3'($urandom_range(0, 7));
      tick();
      if (i == 1500) async_reset();
    end
    quiet();
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
